// File: rtl/cv32e40p_obi_mem_arbiter.sv
// Two-to-one OBI arbiter: instruction fetch and data ports share one memory port.
// Address phases arbitrate round-robin or data-first; an in-order ID FIFO routes responses back.
module cv32e40p_obi_mem_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_PRIORITY   = 0
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic                                     instr_req_i,
    input  logic [ADDR_WIDTH-1:0]                    instr_addr_i,
    output logic                                     instr_gnt_o,
    output logic                                     instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    instr_rdata_o,
    input  logic                                     data_req_i,
    input  logic [ADDR_WIDTH-1:0]                    data_addr_i,
    input  logic                                     data_we_i,
    input  logic [3:0]                               data_be_i,
    input  logic [DATA_WIDTH-1:0]                    data_wdata_i,
    output logic                                     data_gnt_o,
    output logic                                     data_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    data_rdata_o,
    output logic                                     mem_req_o,
    output logic [ADDR_WIDTH-1:0]                    mem_addr_o,
    output logic                                     mem_we_o,
    output logic [3:0]                               mem_be_o,
    output logic [DATA_WIDTH-1:0]                    mem_wdata_o,
    input  logic                                     mem_gnt_i,
    input  logic                                     mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    mem_rdata_i,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_o,
    output logic                                     err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // FIFO entry / requester ID: 0 = instr, 1 = data
    logic [MAX_OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]           wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       lock_q, lock_d;
    logic                       lock_data_q, lock_data_d;
    logic                       last_data_q, last_data_d;
    logic                       err_q, err_d;

    logic full, sel_vld, sel_data, handshake, pop, head;

    always_comb begin
        full     = (count_q == CNT_W'(MAX_OUTSTANDING));
        sel_vld  = 1'b0;
        sel_data = 1'b0;
        if (!full) begin
            if (lock_q) begin
                sel_vld  = 1'b1;
                sel_data = lock_data_q;
            end else if (instr_req_i && data_req_i) begin
                sel_vld  = 1'b1;
                sel_data = (DATA_PRIORITY != 0) ? 1'b1 : ~last_data_q;
            end else if (instr_req_i) begin
                sel_vld  = 1'b1;
            end else if (data_req_i) begin
                sel_vld  = 1'b1;
                sel_data = 1'b1;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_wdata_o = '0;
        if (sel_vld && sel_data) begin
            mem_req_o   = data_req_i;
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
        end else if (sel_vld) begin
            mem_req_o   = instr_req_i;
            mem_addr_o  = instr_addr_i;
            mem_be_o    = 4'hF;
        end
    end

    assign instr_gnt_o    = sel_vld & ~sel_data & mem_gnt_i;
    assign data_gnt_o     = sel_vld &  sel_data & mem_gnt_i;
    assign handshake      = mem_req_o & mem_gnt_i;

    assign pop            = mem_rvalid_i & (count_q != '0);
    assign head           = fifo_q[rptr_q];
    assign instr_rvalid_o = pop & ~head;
    assign data_rvalid_o  = pop &  head;
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign outstanding_o  = count_q;
    assign err_o          = err_q;

    always_comb begin
        fifo_d      = fifo_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        lock_d      = lock_q;
        lock_data_d = lock_data_q;
        last_data_d = last_data_q;
        err_d       = err_q | (mem_rvalid_i & (count_q == '0));
        if (handshake) begin
            fifo_d[wptr_q] = sel_data;
            wptr_d         = ptr_inc(wptr_q);
            lock_d         = 1'b0;
            last_data_d    = sel_data;
        end else if (mem_req_o) begin
            // Ungranted selection is held so the other port cannot preempt it
            lock_d      = 1'b1;
            lock_data_d = sel_data;
        end
        if (pop) rptr_d = ptr_inc(rptr_q);
        case ({handshake, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fifo_q      <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            lock_q      <= 1'b0;
            lock_data_q <= 1'b0;
            last_data_q <= 1'b1;   // instr wins the first tie after reset
            err_q       <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            lock_q      <= lock_d;
            lock_data_q <= lock_data_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_cv32e40p_obi_mem_arbiter.sv
// Directed bench for cv32e40p_obi_mem_arbiter: responses are scoreboarded, per-cycle
// grant/mux/occupancy values are compared against hand-computed constants.
module tb_cv32e40p_obi_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_req, data_req, data_we, mem_gnt, mem_rvalid;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_be;
    logic        instr_gnt, instr_rvalid, data_gnt, data_rvalid;
    logic [31:0] instr_rdata, data_rdata;
    logic        mem_req, mem_we, err;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [1:0]  outstanding;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
    } exp_t;
    exp_t sb[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cv32e40p_obi_mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .DATA_PRIORITY(0)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata),
        .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we),
        .data_be_i(data_be), .data_wdata_i(data_wdata), .data_gnt_o(data_gnt),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .outstanding_o(outstanding), .err_o(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every presented response must match the scoreboard head
    always @(negedge clk) begin
        if (instr_rvalid || data_rvalid) begin
            if (instr_rvalid && data_rvalid) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid_both: got 1 1 expected one-hot");
            end else if (sb.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL rvalid_unexpected: got port %0d expected none", data_rvalid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_port", {31'b0, data_rvalid}, {31'b0, e.port});
                chk("resp_rdata", data_rvalid ? data_rdata : instr_rdata, e.rdata);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        instr_req = 0; instr_addr = 0;
        data_req = 0; data_addr = 0; data_we = 0; data_be = 0; data_wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic respond(input logic port, input logic [31:0] rd);
        mem_rvalid = 1; mem_rdata = rd;
        sb.push_back('{port: port, rdata: rd});
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        tick();
        #3;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_gnts", {30'b0, instr_gnt, data_gnt}, 0);
        chk("rst_outstanding", {30'b0, outstanding}, 0);
        chk("rst_err", {31'b0, err}, 0);
        tick();
        rst = 0;

        // Single fetch
        instr_req = 1; instr_addr = 32'h180; mem_gnt = 1;
        #3;
        chk("f_instr_gnt", {31'b0, instr_gnt}, 1);
        chk("f_data_gnt", {31'b0, data_gnt}, 0);
        chk("f_mem_addr", mem_addr, 32'h180);
        chk("f_mem_be_we", {27'b0, mem_be, mem_we}, {27'b0, 4'hF, 1'b0});
        tick();
        idle(); respond(0, 32'h0000_0013);
        #3;
        chk("f_outst1", {30'b0, outstanding}, 1);
        tick();
        idle();
        #3;
        chk("f_outst0", {30'b0, outstanding}, 0);

        // Round-robin from a fresh reset: instr, data, instr, data
        do_reset();
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin
                instr_req = 1; instr_addr = 32'h100;
                data_req = 1; data_addr = 32'h2000; data_be = 4'hF;
                mem_gnt = 1;
            end
            if (k >= 1) respond(((k - 1) % 2) == 1, 32'hA0 + k - 1);
            #3;
            if (k < 4) begin
                chk("rr_instr_gnt", {31'b0, instr_gnt}, (k % 2) == 0);
                chk("rr_data_gnt", {31'b0, data_gnt}, (k % 2) == 1);
                chk("rr_mem_addr", mem_addr, (k % 2) ? 32'h2000 : 32'h100);
            end
            tick();
        end
        idle();
        #3;
        chk("rr_outst0", {30'b0, outstanding}, 0);

        // Lock: stalled data store must not be preempted by instr
        for (int k = 0; k < 5; k++) begin
            idle();
            data_addr = 32'h1000_0000; data_we = 1; data_be = 4'b0011; data_wdata = 32'hDEAD_BEEF;
            data_req = (k < 4);
            instr_req = (k >= 1); instr_addr = 32'h200;
            mem_gnt = (k >= 3);
            #3;
            if (k < 4) begin
                chk("lk_mem_addr", mem_addr, 32'h1000_0000);
                chk("lk_mem_we_be", {27'b0, mem_we, mem_be}, {27'b0, 1'b1, 4'b0011});
                chk("lk_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
                chk("lk_instr_gnt", {31'b0, instr_gnt}, 0);
                chk("lk_data_gnt", {31'b0, data_gnt}, (k == 3));
            end else begin
                chk("lk_after_instr_gnt", {31'b0, instr_gnt}, 1);
                chk("lk_after_addr", mem_addr, 32'h200);
                chk("lk_after_outst", {30'b0, outstanding}, 1);
            end
            tick();
        end
        idle(); respond(1, 32'h55);
        #3;
        chk("lk_outst2", {30'b0, outstanding}, 2);
        tick();
        idle(); respond(0, 32'h66);
        tick();
        idle();
        #3;
        chk("lk_outst0", {30'b0, outstanding}, 0);

        // Full: two grants with no response block the port
        idle(); instr_req = 1; instr_addr = 32'h300; mem_gnt = 1;
        tick();
        tick();
        data_req = 1; data_addr = 32'h400; data_be = 4'hF;
        #3;
        chk("fu_outst2", {30'b0, outstanding}, 2);
        chk("fu_mem_req", {31'b0, mem_req}, 0);
        chk("fu_gnts", {30'b0, instr_gnt, data_gnt}, 0);
        tick();
        respond(0, 32'h77);
        #3;
        chk("fu_pop_same_cycle_req", {31'b0, mem_req}, 0);
        tick();
        mem_rvalid = 0;
        #3;
        chk("fu_reassert_req", {31'b0, mem_req}, 1);
        chk("fu_data_gnt", {31'b0, data_gnt}, 1);
        chk("fu_instr_gnt", {31'b0, instr_gnt}, 0);
        tick();
        idle(); respond(0, 32'h88);
        tick();
        idle(); respond(1, 32'h99);
        tick();
        idle();
        #3;
        chk("fu_outst0", {30'b0, outstanding}, 0);
        chk("fu_err_clean", {31'b0, err}, 0);

        // Spurious response on empty FIFO
        mem_rvalid = 1; mem_rdata = 32'hBAD;
        #3;
        chk("sp_rvalids", {30'b0, instr_rvalid, data_rvalid}, 0);
        tick();
        idle();
        #3;
        chk("sp_err_set", {31'b0, err}, 1);
        tick();
        #3;
        chk("sp_err_held", {31'b0, err}, 1);

        // Reset mid-flight drops the outstanding entry
        do_reset();
        #3;
        chk("rm_err_cleared", {31'b0, err}, 0);
        tick();
        instr_req = 1; instr_addr = 32'h500; mem_gnt = 1;
        tick();
        idle(); rst = 1;
        tick();
        rst = 0;
        mem_rvalid = 1; mem_rdata = 32'h1234;
        #3;
        chk("rm_outst0", {30'b0, outstanding}, 0);
        chk("rm_rvalids", {30'b0, instr_rvalid, data_rvalid}, 0);
        tick();
        idle();
        #3;
        chk("rm_err_set", {31'b0, err}, 1);
        tick();

        chk("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
